wallace_mac: RTL and testbench

Pipelined unsigned multiply-accumulate stage that consumes the team's combinational 8x8 Wallace tree multiplier (a, b -> 16-bit z). It accepts a stream of 8-bit operand pairs under valid/ready and sums their products over a vector delimited by in_last. It emits one accumulated result per vector under valid/ready. It is the registered, flow-controlled consumer that turns the multiplier into a dot-product engine.

---
 rtl/wallace_mac_if.sv | 26 ++
 rtl/wallace_mac.sv | 121 ++++++++++++
 tb/tb_wallace_mac.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wallace_mac_if.sv
// Operand/result handshake bundle for the wallace_mac dot-product stage.
interface wallace_mac_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/wallace_mac.sv
// Three-stage unsigned 8x8 multiply-accumulate over in_last-delimited vectors.
// S1 operand regs, S2 Wallace product reg, S3 accumulator and result reg.
module wallace_mac #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    wallace_mac_if.slave  bus
);

    function automatic logic [15:0] maj(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        logic [15:0] m;
        m = (x & y) | (x & z) | (y & z);
        return {m[14:0], 1'b0};
    endfunction

    // Word-level Wallace reduction: 8 rows -> 6 -> 4 -> 3 -> 2, then one adder.
    function automatic logic [15:0] wallace(
        input logic [7:0] x,
        input logic [7:0] y
    );
        logic [15:0] pp [8];
        logic [15:0] s0, c0, s1, c1, s2, c2;
        logic [15:0] s3, c3, s4, c4, s5, c5;
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'h00, y & {8{x[i]}}} << i;
        end
        s0 = pp[0] ^ pp[1] ^ pp[2];
        c0 = maj(pp[0], pp[1], pp[2]);
        s1 = pp[3] ^ pp[4] ^ pp[5];
        c1 = maj(pp[3], pp[4], pp[5]);
        s2 = s0 ^ c0 ^ s1;
        c2 = maj(s0, c0, s1);
        s3 = c1 ^ pp[6] ^ pp[7];
        c3 = maj(c1, pp[6], pp[7]);
        s4 = s2 ^ c2 ^ s3;
        c4 = maj(s2, c2, s3);
        s5 = s4 ^ c4 ^ c3;
        c5 = maj(s4, c4, c3);
        return s5 + c5;
    endfunction

    logic             s1_valid;
    logic             s1_last;
    logic [7:0]       s1_a;
    logic [7:0]       s1_b;
    logic             s2_valid;
    logic             s2_last;
    logic [15:0]      s2_prod;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             o_valid;
    logic [ACC_W-1:0] o_data;
    logic [CNT_W-1:0] o_count;
    logic             o_ovf;
    logic             stall;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_nx;

    assign stall  = o_valid & ~bus.out_ready & s2_valid & s2_last;
    assign sum    = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, s2_prod};
    assign cnt_nx = cnt + CNT_W'(1);

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_count = o_count;
    assign bus.out_ovf   = o_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_count  <= '0;
            o_ovf    <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                o_valid <= 1'b0;
            end
            if (!stall) begin
                s1_valid <= bus.in_valid;
                s1_last  <= bus.in_last;
                s1_a     <= bus.in_a;
                s1_b     <= bus.in_b;
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_prod  <= wallace(s1_a, s1_b);
                if (s2_valid && !s2_last) begin
                    acc <= sum[ACC_W-1:0];
                    cnt <= cnt_nx;
                    ovf <= ovf | sum[ACC_W];
                end else if (s2_valid && s2_last) begin
                    o_data  <= sum[ACC_W-1:0];
                    o_count <= cnt_nx;
                    o_ovf   <= ovf | sum[ACC_W];
                    o_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac.sv
// Randomized and directed bench for wallace_mac against a vector-sum model.
module tb_wallace_mac;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wallace_mac_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    wallace_mac #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    rand_ready = 1'b0;
    res_t  expq[$];
    res_t  got[$];
    longint m_sum = 0;
    int    m_cnt = 0;

    task automatic check(input string name, input longint act,
                         input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Model: whole-vector sums in wide arithmetic, results queued in order.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data", bus.out_data, 0);
            m_sum = 0;
            m_cnt = 0;
            expq.delete();
        end else begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("out_data", bus.out_data, expq[0].data);
                    check("out_count", bus.out_count, expq[0].count);
                    check("out_ovf", bus.out_ovf, expq[0].ovf);
                    if (bus.out_ready) begin
                        got.push_back(expq[0]);
                        void'(expq.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m_sum += longint'(bus.in_a) * longint'(bus.in_b);
                m_cnt++;
                if (bus.in_last) begin
                    expq.push_back('{data: m_sum[ACC_W-1:0],
                                     count: m_cnt[CNT_W-1:0],
                                     ovf: (m_sum >> ACC_W) != 0});
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (got.size() >= n) break;
            @(posedge clk);
        end
        check("result_count", got.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input int idx, input longint d,
                             input longint c, input longint o);
        if (idx < got.size()) begin
            check("lit_data", got[idx].data, d);
            check("lit_count", got[idx].count, c);
            check("lit_ovf", got[idx].ovf, o);
        end else begin
            check("lit_missing", idx, got.size());
        end
    endtask

    initial begin
        int len;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_count", bus.out_count, 0);
        check("reset_out_ovf", bus.out_ovf, 0);
        @(posedge clk);
        #1;

        // single beat, exact latency and one-cycle valid
        got.delete();
        send(8'd255, 8'd255, 1'b1);
        @(negedge clk);
        check("lat_n1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_n3_valid", bus.out_valid, 1);
        check("lat_n3_data", bus.out_data, 65025);
        @(negedge clk);
        check("lat_n4_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check_got(0, 65025, 1, 0);

        // four-beat vector
        got.delete();
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        wait_got(1);
        check_got(0, 100, 4, 0);

        // accumulator wrap and count wrap, then overflow flag clears
        got.delete();
        for (int i = 0; i < 259; i++) send(8'd255, 8'd255, i == 258);
        send(8'd2, 8'd3, 1'b1);
        wait_got(2);
        check_got(0, 64259, 3, 1);
        check_got(1, 6, 1, 0);

        // backpressure on back-to-back single-beat vectors
        got.delete();
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'd2, 8'd2, 1'b1);
                send(8'd3, 8'd3, 1'b1);
                send(8'd4, 8'd4, 1'b1);
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_valid", bus.out_valid, 1);
                check("bp_hold4", bus.out_data, 4);
                check("bp_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_next9", bus.out_data, 9);
                repeat (4) @(negedge clk);
                check("bp_hold9", bus.out_data, 9);
                check("bp_in_ready2", bus.in_ready, 0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_got(3);
        check_got(0, 4, 1, 0);
        check_got(1, 9, 1, 0);
        check_got(2, 16, 1, 0);

        // reset mid-vector discards the partial sum
        got.delete();
        send(8'd10, 8'd10, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_data", bus.out_data, 0);
        check("rst_async_count", bus.out_count, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'd3, 8'd3, 1'b1);
        wait_got(1);
        check_got(0, 9, 1, 0);

        // continuous stream of single-beat vectors
        fork
            begin
                for (int k = 1; k <= 20; k++) send(8'(k), 8'd1, 1'b1);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                for (int k = 1; k <= 20; k++) begin
                    check("stream_valid", bus.out_valid, 1);
                    check("stream_data", bus.out_data, k);
                    @(negedge clk);
                end
                check("stream_end", bus.out_valid, 0);
            end
        join
        @(posedge clk);
        #1;

        // random vectors with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int v = 0; v < 300; v++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(8'($urandom), 8'($urandom), j == len - 1);
            end
        end
        rand_ready = 1'b0;
        #2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (expq.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
